// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing generator/detector pair.
package vga_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } det_state_t;

    localparam logic POL_NEG = 1'b0;
    localparam logic POL_POS = 1'b1;

    // 800x600@60 reference geometry
    localparam int H800_TOTAL  = 1056;
    localparam int H800_ACTIVE = 800;
    localparam int H800_SYNC   = 128;
    localparam int V600_TOTAL  = 628;
    localparam int V600_ACTIVE = 600;
    localparam int V600_SYNC   = 4;

endpackage

// File: rtl/vga_sync_edge.sv
// Normalises one sync/enable input to active-high, registers it once and
// flags rising/falling edges of the normalised level.
module vga_sync_edge #(
    parameter logic POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic act,
    output logic rise,
    output logic fall
);

    logic act_q;
    logic act_d;

    always_comb begin
        act_d = (sig_in == POL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q <= 1'b0;
        end else begin
            act_q <= act_d;
        end
    end

    assign act  = act_d;
    assign rise = act_d & ~act_q;
    assign fall = ~act_d & act_q;

endmodule

// File: rtl/vga_timing_detector.sv
// Receive-side VGA timing measurement: line/frame geometry, pixel coordinate
// recovery and lock qualification for a hsync/vsync/de source.
module vga_timing_detector
    import vga_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int HSPP        = 1,
    parameter int VSPP        = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic             pix_valid,
    output logic [WIDTH-1:0] pix_x,
    output logic [WIDTH-1:0] pix_y,
    output logic [WIDTH-1:0] htotal,
    output logic [WIDTH-1:0] hactive,
    output logic [WIDTH-1:0] hsw,
    output logic [WIDTH-1:0] vtotal,
    output logic [WIDTH-1:0] vactive,
    output logic [WIDTH-1:0] vsw,
    output logic             frame_start,
    output logic             locked,
    output logic             timing_change
);

    typedef struct packed {
        logic [WIDTH-1:0] ht;
        logic [WIDTH-1:0] ha;
        logic [WIDTH-1:0] hw;
        logic [WIDTH-1:0] vt;
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vw;
    } meas_t;

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [2:0]       POLS = {POL_POS, (VSPP != 0), (HSPP != 0)};

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == ONES) ? v : v + ONE;
    endfunction

    logic [2:0] raw_in, act, rise, fall;
    assign raw_in = {de, vsync, hsync};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            vga_sync_edge #(.POL(POLS[gi])) u_edge (
                .clk    (clk),
                .rst    (rst),
                .sig_in (raw_in[gi]),
                .act    (act[gi]),
                .rise   (rise[gi]),
                .fall   (fall[gi])
            );
        end
    endgenerate

    logic hs_a, vs_a, de_a, hs_rise, vs_rise, de_rise, hs_fall, de_fall;
    logic unused_vs_fall;
    assign hs_a    = act[0];
    assign vs_a    = act[1];
    assign de_a    = act[2];
    assign hs_rise = rise[0];
    assign vs_rise = rise[1];
    assign de_rise = rise[2];
    assign hs_fall = fall[0];
    assign de_fall = fall[2];
    assign unused_vs_fall = fall[1];

    logic [WIDTH-1:0] hper_q, hper_d, line_len_q, line_len_d;
    logic [WIDTH-1:0] de_cnt_q, de_cnt_d, line_act_q, line_act_d;
    logic [WIDTH-1:0] hs_cnt_q, hs_cnt_d, line_sw_q, line_sw_d;
    logic [WIDTH-1:0] lines_q, lines_d, act_lines_q, act_lines_d, vs_lines_q, vs_lines_d;
    logic [WIDTH-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic             pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
    logic             locked_q, locked_d, timing_change_q, timing_change_d;
    logic             ref_valid_q, ref_valid_d;
    logic [3:0]       match_cnt_q, match_cnt_d, match_inc;
    meas_t            meas_q, meas_d, ref_q, ref_d, meas_new;
    det_state_t       state_q, state_d;

    always_comb begin
        hper_d          = hs_rise ? '0 : sat_inc(hper_q);
        line_len_d      = line_len_q;
        de_cnt_d        = de_cnt_q;
        line_act_d      = line_act_q;
        hs_cnt_d        = hs_cnt_q;
        line_sw_d       = line_sw_q;
        lines_d         = hs_rise ? sat_inc(lines_q) : lines_q;
        act_lines_d     = de_fall ? sat_inc(act_lines_q) : act_lines_q;
        vs_lines_d      = (hs_rise && vs_a) ? sat_inc(vs_lines_q) : vs_lines_q;
        pix_valid_d     = de_a;
        pix_x_d         = pix_x_q;
        pix_y_d         = pix_y_q;
        frame_start_d   = vs_rise;
        meas_d          = meas_q;
        ref_d           = ref_q;
        ref_valid_d     = ref_valid_q;
        match_cnt_d     = match_cnt_q;
        match_inc       = match_cnt_q + 4'd1;
        state_d         = state_q;
        timing_change_d = 1'b0;

        if (hs_rise) begin
            line_len_d = sat_inc(hper_q);
            if (de_cnt_q != '0) begin
                line_act_d = de_cnt_q;
            end
            de_cnt_d = '0;
        end else if (de_a) begin
            de_cnt_d = sat_inc(de_cnt_q);
        end

        if (hs_fall) begin
            line_sw_d = hs_cnt_q;
            hs_cnt_d  = '0;
        end else if (hs_a) begin
            hs_cnt_d = sat_inc(hs_cnt_q);
        end

        // A de fall coinciding with vs rise closes the old frame; a
        // coinciding hs rise opens the new one.
        meas_new = '{ht: line_len_q, ha: line_act_q, hw: line_sw_q,
                     vt: lines_q, va: act_lines_d, vw: vs_lines_q};

        if (vs_rise) begin
            meas_d      = meas_new;
            lines_d     = hs_rise ? ONE : '0;
            act_lines_d = '0;
            vs_lines_d  = hs_rise ? ONE : '0;
        end

        if (de_a) begin
            pix_x_d = de_rise ? '0 : sat_inc(pix_x_q);
            pix_y_d = vs_rise ? '0 : act_lines_q;
        end

        if (vs_rise) begin
            unique case (state_q)
                SEARCH: begin
                    state_d     = MEASURE;
                    ref_valid_d = 1'b0;
                    match_cnt_d = '0;
                end
                MEASURE: begin
                    if (!ref_valid_q) begin
                        ref_d       = meas_new;
                        ref_valid_d = 1'b1;
                    end else if (meas_new == ref_q) begin
                        match_cnt_d = match_inc;
                        if (match_inc == 4'(LOCK_FRAMES)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        ref_d       = meas_new;
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (meas_new != ref_q) begin
                        state_d         = SEARCH;
                        timing_change_d = 1'b1;
                        ref_valid_d     = 1'b0;
                        match_cnt_d     = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Loss of signal: a stalled line or frame counter drops lock silently.
        if (hper_q == ONES || lines_q == ONES) begin
            state_d         = SEARCH;
            ref_valid_d     = 1'b0;
            match_cnt_d     = '0;
            timing_change_d = 1'b0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hper_q          <= '0;
            line_len_q      <= '0;
            de_cnt_q        <= '0;
            line_act_q      <= '0;
            hs_cnt_q        <= '0;
            line_sw_q       <= '0;
            lines_q         <= '0;
            act_lines_q     <= '0;
            vs_lines_q      <= '0;
            pix_valid_q     <= 1'b0;
            pix_x_q         <= '0;
            pix_y_q         <= '0;
            frame_start_q   <= 1'b0;
            meas_q          <= '0;
            ref_q           <= '0;
            ref_valid_q     <= 1'b0;
            match_cnt_q     <= '0;
            state_q         <= SEARCH;
            locked_q        <= 1'b0;
            timing_change_q <= 1'b0;
        end else begin
            hper_q          <= hper_d;
            line_len_q      <= line_len_d;
            de_cnt_q        <= de_cnt_d;
            line_act_q      <= line_act_d;
            hs_cnt_q        <= hs_cnt_d;
            line_sw_q       <= line_sw_d;
            lines_q         <= lines_d;
            act_lines_q     <= act_lines_d;
            vs_lines_q      <= vs_lines_d;
            pix_valid_q     <= pix_valid_d;
            pix_x_q         <= pix_x_d;
            pix_y_q         <= pix_y_d;
            frame_start_q   <= frame_start_d;
            meas_q          <= meas_d;
            ref_q           <= ref_d;
            ref_valid_q     <= ref_valid_d;
            match_cnt_q     <= match_cnt_d;
            state_q         <= state_d;
            locked_q        <= locked_d;
            timing_change_q <= timing_change_d;
        end
    end

    assign pix_valid     = pix_valid_q;
    assign pix_x         = pix_x_q;
    assign pix_y         = pix_y_q;
    assign htotal        = meas_q.ht;
    assign hactive       = meas_q.ha;
    assign hsw           = meas_q.hw;
    assign vtotal        = meas_q.vt;
    assign vactive       = meas_q.va;
    assign vsw           = meas_q.vw;
    assign frame_start   = frame_start_q;
    assign locked        = locked_q;
    assign timing_change = timing_change_q;

endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench: a positive-polarity and a negative-polarity detector fed
// from one raster generator, with hand-computed geometry and lock timing.
module tb_vga_timing_detector;
    import vga_pkg::*;

    localparam int W = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic hs_l = 1'b0, vs_l = 1'b0, de_l = 1'b0;
    logic p_hsync, p_vsync, n_hsync, n_vsync;
    assign p_hsync = hs_l;
    assign p_vsync = vs_l;
    assign n_hsync = ~hs_l;
    assign n_vsync = ~vs_l;

    logic         p_pv, p_fs, p_lk, p_tc, n_pv, n_fs, n_lk, n_tc;
    logic [W-1:0] p_px, p_py, p_ht, p_ha, p_hw, p_vt, p_va, p_vw;
    logic [W-1:0] n_px, n_py, n_ht, n_ha, n_hw, n_vt, n_va, n_vw;

    vga_timing_detector #(.WIDTH(W), .HSPP(1), .VSPP(1), .LOCK_FRAMES(2)) dut_p (
        .clk(clk), .rst(rst), .hsync(p_hsync), .vsync(p_vsync), .de(de_l),
        .pix_valid(p_pv), .pix_x(p_px), .pix_y(p_py),
        .htotal(p_ht), .hactive(p_ha), .hsw(p_hw),
        .vtotal(p_vt), .vactive(p_va), .vsw(p_vw),
        .frame_start(p_fs), .locked(p_lk), .timing_change(p_tc)
    );

    vga_timing_detector #(.WIDTH(W), .HSPP(0), .VSPP(0), .LOCK_FRAMES(2)) dut_n (
        .clk(clk), .rst(rst), .hsync(n_hsync), .vsync(n_vsync), .de(de_l),
        .pix_valid(n_pv), .pix_x(n_px), .pix_y(n_py),
        .htotal(n_ht), .hactive(n_ha), .hsw(n_hw),
        .vtotal(n_vt), .vactive(n_va), .vsw(n_vw),
        .frame_start(n_fs), .locked(n_lk), .timing_change(n_tc)
    );

    logic         sel = 1'b0;
    logic         o_pv, o_fs, o_lk, o_tc;
    logic [W-1:0] o_px, o_py, o_ht, o_ha, o_hw, o_vt, o_va, o_vw;
    assign o_pv = sel ? n_pv : p_pv;
    assign o_fs = sel ? n_fs : p_fs;
    assign o_lk = sel ? n_lk : p_lk;
    assign o_tc = sel ? n_tc : p_tc;
    assign o_px = sel ? n_px : p_px;
    assign o_py = sel ? n_py : p_py;
    assign o_ht = sel ? n_ht : p_ht;
    assign o_ha = sel ? n_ha : p_ha;
    assign o_hw = sel ? n_hw : p_hw;
    assign o_vt = sel ? n_vt : p_vt;
    assign o_va = sel ? n_va : p_va;
    assign o_vw = sel ? n_vw : p_vw;

    int checks = 0;
    int failures = 0;
    int rise_idx = 0;
    int tc_count = 0;
    logic chk_pix = 1'b0;
    logic prev_vsr = 1'b0, prev_vs = 1'b0, prev_de = 1'b0;
    int prev_h = 0, prev_v = 0;
    logic seen_locked [0:15];
    logic seen_tc [0:15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One pixel clock: check what the previous drive produced, then drive anew.
    task automatic cyc(input logic hs, input logic vs, input logic de, input int h, input int v);
        @(negedge clk);
        if (prev_vsr) begin
            rise_idx++;
            if (rise_idx < 16) begin
                seen_locked[rise_idx] = o_lk;
                seen_tc[rise_idx]     = o_tc;
            end
        end
        if (chk_pix) begin
            check("frame_start", 32'(o_fs), 32'(prev_vsr));
            check("pix_valid", 32'(o_pv), 32'(prev_de));
            if (prev_de) begin
                check("pix_x", 32'(o_px), 32'(prev_h));
                check("pix_y", 32'(o_py), 32'(prev_v));
            end
        end
        if (o_tc) tc_count++;
        hs_l = hs;
        vs_l = vs;
        de_l = de;
        prev_vsr = vs && !prev_vs;
        prev_vs  = vs;
        prev_de  = de;
        prev_h   = h;
        prev_v   = v;
    endtask

    task automatic frame(input int ht, input int ha, input int hfp, input int hw,
                         input int vt, input int va, input int vfp, input int vw,
                         input int voff, input int ncyc);
        int n;
        int vs_s;
        int vs_e;
        int pos;
        n = 0;
        vs_s = (va + vfp) * ht + voff;
        vs_e = vs_s + vw * ht;
        for (int v = 0; v < vt; v++) begin
            for (int h = 0; h < ht; h++) begin
                if (ncyc != 0 && n >= ncyc) return;
                n++;
                pos = v * ht + h;
                cyc((h >= ha + hfp) && (h < ha + hfp + hw), (pos >= vs_s) && (pos < vs_e),
                    (h < ha) && (v < va), h, v);
            end
        end
    endtask

    task automatic small_frames(input int count, input logic pix_last);
        for (int f = 1; f <= count; f++) begin
            chk_pix = pix_last && (f == count);
            frame(20, 12, 2, 3, 10, 6, 1, 2, 0, 0);
        end
        chk_pix = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        hs_l = 1'b0; vs_l = 1'b0; de_l = 1'b0;
        prev_vsr = 1'b0; prev_vs = 1'b0; prev_de = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            check("reset_outputs_zero", 32'(|{o_pv, o_fs, o_lk, o_tc, o_px, o_py, o_ht, o_ha,
                                               o_hw, o_vt, o_va, o_vw}), 32'd0);
        end
        sel = 1'b0;
        #1;
        rst = 1'b0;

        // 800-wide line timing, short frame, positive polarity
        rise_idx = 0;
        for (int f = 1; f <= 5; f++) begin
            chk_pix = (f == 5);
            frame(H800_TOTAL, H800_ACTIVE, 40, H800_SYNC, 6, 3, 1, 2, 0, 0);
        end
        chk_pix = 1'b0;
        check("p_locked_after_rise3", 32'(seen_locked[3]), 32'd0);
        check("p_locked_after_rise4", 32'(seen_locked[4]), 32'd1);
        check("p_htotal", 32'(o_ht), 32'd1056);
        check("p_hactive", 32'(o_ha), 32'd800);
        check("p_hsw", 32'(o_hw), 32'd128);
        check("p_vtotal", 32'(o_vt), 32'd6);
        check("p_vactive", 32'(o_va), 32'd3);
        check("p_vsw", 32'(o_vw), 32'd2);
        check("p_timing_change_count", 32'(tc_count), 32'd0);

        // Small timing, negative polarity
        sel = 1'b1;
        #1;
        do_reset();
        rise_idx = 0;
        tc_count = 0;
        small_frames(5, 1'b1);
        check("n_locked_after_rise3", 32'(seen_locked[3]), 32'd0);
        check("n_locked_after_rise4", 32'(seen_locked[4]), 32'd1);
        check("n_htotal", 32'(o_ht), 32'd20);
        check("n_hactive", 32'(o_ha), 32'd12);
        check("n_hsw", 32'(o_hw), 32'd3);
        check("n_vtotal", 32'(o_vt), 32'd10);
        check("n_vactive", 32'(o_va), 32'd6);
        check("n_vsw", 32'(o_vw), 32'd2);

        // One frame with a longer line breaks lock, then relock
        rise_idx = 0;
        frame(21, 12, 2, 3, 10, 6, 1, 2, 0, 0);
        small_frames(4, 1'b0);
        check("chg_timing_change_rise1", 32'(seen_tc[1]), 32'd1);
        check("chg_locked_rise1", 32'(seen_locked[1]), 32'd0);
        check("chg_timing_change_rise2", 32'(seen_tc[2]), 32'd0);
        check("chg_locked_rise4", 32'(seen_locked[4]), 32'd0);
        check("chg_locked_rise5", 32'(seen_locked[5]), 32'd1);
        check("chg_timing_change_count", 32'(tc_count), 32'd1);
        check("chg_htotal_restored", 32'(o_ht), 32'd20);

        // Loss of signal: all inputs idle until hper saturates
        tc_count = 0;
        n = 0;
        while (o_lk && n < 5000) begin
            cyc(1'b0, 1'b0, 1'b0, 0, 0);
            n++;
        end
        check("los_drop_cycle_in_range", 32'((n >= 4080) && (n <= 4100)), 32'd1);
        check("los_locked", 32'(o_lk), 32'd0);
        check("los_timing_change_count", 32'(tc_count), 32'd0);

        // Relock, then reset mid-line
        rise_idx = 0;
        small_frames(5, 1'b0);
        check("rl_locked_after_rise4", 32'(seen_locked[4]), 32'd1);
        frame(20, 12, 2, 3, 10, 6, 1, 2, 0, 3 * 20 + 6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_outputs_zero", 32'(|{o_pv, o_fs, o_lk, o_tc, o_px, o_py, o_ht, o_ha,
                                            o_hw, o_vt, o_va, o_vw}), 32'd0);
        prev_vsr = 1'b0;
        prev_vs = 1'b0;
        rise_idx = 0;
        small_frames(4, 1'b0);
        check("midrst_locked_after_rise3", 32'(seen_locked[3]), 32'd0);
        check("midrst_locked_after_rise4", 32'(seen_locked[4]), 32'd1);

        // vsync rising on the same clock as hsync
        tc_count = 0;
        chk_pix = 1'b1;
        for (int f = 0; f < 3; f++) begin
            frame(20, 12, 2, 3, 10, 6, 1, 2, 14, 0);
        end
        chk_pix = 1'b0;
        check("coinc_vtotal", 32'(o_vt), 32'd10);
        check("coinc_vsw", 32'(o_vw), 32'd2);
        check("coinc_locked", 32'(o_lk), 32'd1);
        check("coinc_timing_change_count", 32'(tc_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
